// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the decode stage: ALU/AGU opcodes, function
// codes, flag bit positions and the stage FSM state type.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] ALU_SLL        = 4'd0;
    localparam logic [3:0] ALU_SRL        = 4'd1;
    localparam logic [3:0] ALU_SRA        = 4'd2;
    localparam logic [3:0] ALU_SIGNED_ADD = 4'd3;
    localparam logic [3:0] ALU_ADD        = 4'd4;
    localparam logic [3:0] ALU_SUB        = 4'd5;
    localparam logic [3:0] ALU_AND        = 4'd6;
    localparam logic [3:0] ALU_OR         = 4'd7;
    localparam logic [3:0] ALU_XOR        = 4'd8;
    localparam logic [3:0] ALU_NOR        = 4'd9;
    localparam logic [3:0] ALU_SLT        = 4'd10;
    localparam logic [3:0] ALU_SHIFT_LEFT = ALU_SLL;

    localparam logic [2:0] AGU_REG    = 3'b000;
    localparam logic [2:0] AGU_MEM    = 3'b001;
    localparam logic [2:0] AGU_BRANCH = 3'b010;
    localparam logic [2:0] AGU_JUMP   = 3'b011;

    localparam logic [1:0] SRC_A_PC  = 2'b00;
    localparam logic [1:0] SRC_A_REG = 2'b01;
    localparam logic [1:0] SRC_A_IMM = 2'b11;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] IMM_ADD = 3'b000;
    localparam logic [2:0] IMM_SLT = 3'b010;
    localparam logic [2:0] IMM_AND = 3'b100;
    localparam logic [2:0] IMM_OR  = 3'b101;
    localparam logic [2:0] IMM_XOR = 3'b110;
    localparam logic [2:0] IMM_LUI = 3'b111;

    localparam int FLAGS_W          = 12;
    localparam int FLAG_PC_MODIFY   = 11;
    localparam int FLAG_LINK_RET    = 10;
    localparam int FLAG_ADDR_HI     = 9;
    localparam int FLAG_ADDR_LO     = 8;
    localparam int FLAG_CMP         = 7;
    localparam int FLAG_EQUAL       = 6;
    localparam int FLAG_INMEDIATE   = 5;
    localparam int FLAG_MEM_OP      = 4;
    localparam int FLAG_MEM_TYPE    = 3;
    localparam int FLAG_MEM_SIZE_HI = 2;
    localparam int FLAG_MEM_SIZE_LO = 1;
    localparam int FLAG_UNSIGN      = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps function code and flags to one
// control word. Illegal encodings zero every control field.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4,
    parameter int AGU_OP_W   = 3
) (
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [FLAGS_W-1:0]    flags,
    output logic                  alu_en,
    output logic [1:0]            src_a,
    output logic                  src_b,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  agu_en,
    output logic [AGU_OP_W-1:0]   agu_op,
    output logic                  make_jump,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic                  imm_sext,
    output logic                  illegal
);

    logic [3:0] op;
    logic [2:0] agu;
    logic [1:0] addr_type;
    logic       unused_flags;

    assign addr_type    = flags[FLAG_ADDR_HI:FLAG_ADDR_LO];
    assign unused_flags = ^{flags[FLAG_EQUAL], flags[FLAG_MEM_SIZE_HI:FLAG_MEM_SIZE_LO],
                            flags[FLAG_UNSIGN]};

    always_comb begin
        alu_en    = 1'b0;
        src_a     = SRC_A_PC;
        src_b     = 1'b0;
        op        = '0;
        agu_en    = 1'b0;
        agu       = AGU_REG;
        make_jump = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = '0;
        imm_sext  = 1'b0;
        illegal   = 1'b0;

        if (flags[FLAG_MEM_OP]) begin
            agu_en = 1'b1;
            agu    = AGU_MEM;
            wb_en  = ~flags[FLAG_MEM_TYPE];
            wb_reg = rt;
        end else if (flags[FLAG_PC_MODIFY] && flags[FLAG_CMP]) begin
            alu_en    = 1'b1;
            op        = ALU_SUB;
            src_a     = SRC_A_REG;
            agu_en    = 1'b1;
            agu       = AGU_BRANCH;
            make_jump = 1'b1;
        end else if (flags[FLAG_PC_MODIFY] && (addr_type == 2'b00 || addr_type == 2'b01)) begin
            agu_en    = 1'b1;
            agu       = (addr_type == 2'b00) ? AGU_REG : AGU_JUMP;
            make_jump = 1'b1;
            // Linking jumps compute the return address through the ALU.
            if (flags[FLAG_LINK_RET]) begin
                alu_en = 1'b1;
                op     = ALU_ADD;
                src_a  = SRC_A_PC;
                wb_en  = 1'b1;
                wb_reg = (addr_type == 2'b00) ? rd : REG_ADDR_W'(31);
            end
        end else if (flags[FLAG_INMEDIATE]) begin
            alu_en = 1'b1;
            src_a  = SRC_A_IMM;
            wb_en  = 1'b1;
            wb_reg = rt;
            case (funct[2:0])
                IMM_ADD: begin op = ALU_SIGNED_ADD; imm_sext = 1'b1; end
                IMM_SLT: begin op = ALU_SLT;        imm_sext = 1'b1; end
                IMM_AND: op = ALU_AND;
                IMM_OR:  op = ALU_OR;
                IMM_XOR: op = ALU_XOR;
                IMM_LUI: op = ALU_SHIFT_LEFT;
                default: illegal = 1'b1;
            endcase
        end else begin
            alu_en = 1'b1;
            src_a  = SRC_A_REG;
            wb_en  = 1'b1;
            wb_reg = rd;
            case (funct)
                FN_SLL:  begin op = ALU_SLL; src_b = 1'b1; end
                FN_SRL:  begin op = ALU_SRL; src_b = 1'b1; end
                FN_SRA:  begin op = ALU_SRA; src_b = 1'b1; end
                FN_SLLV: op = ALU_SLL;
                FN_SRLV: op = ALU_SRL;
                FN_SRAV: op = ALU_SRA;
                FN_ADD:  op = ALU_ADD;
                FN_SUB:  op = ALU_SUB;
                FN_AND:  op = ALU_AND;
                FN_OR:   op = ALU_OR;
                FN_XOR:  op = ALU_XOR;
                FN_NOR:  op = ALU_NOR;
                FN_SLT:  op = ALU_SLT;
                default: illegal = 1'b1;
            endcase
        end

        if (wb_reg == '0) wb_en = 1'b0;

        if (illegal) begin
            alu_en    = 1'b0;
            src_a     = '0;
            src_b     = 1'b0;
            op        = '0;
            agu_en    = 1'b0;
            agu       = '0;
            make_jump = 1'b0;
            wb_en     = 1'b0;
            wb_reg    = '0;
            imm_sext  = 1'b0;
        end
    end

    assign alu_op = ALU_OP_W'(op);
    assign agu_op = AGU_OP_W'(agu);

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode pipeline stage: load-use stall, illegal-instruction halt and a
// registered control word with valid/ready flow control.
module decode_ctrl_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int ALU_OP_W        = 4,
    parameter int AGU_OP_W        = 3,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [5:0]            i_funct,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [FLAGS_W-1:0]    i_flags,
    input  logic                  i_ex_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic                  i_flush,
    input  logic                  i_resume,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    output logic                  o_alu_en,
    output logic [1:0]            o_alu_src_a,
    output logic                  o_alu_src_b,
    output logic [ALU_OP_W-1:0]   o_alu_op,
    output logic                  o_agu_en,
    output logic [AGU_OP_W-1:0]   o_agu_op,
    output logic                  o_make_jump,
    output logic                  o_wb_en,
    output logic [REG_ADDR_W-1:0] o_wb_reg,
    output logic                  o_imm_sext,
    output logic                  o_illegal,
    output logic                  o_stall
);

    state_t state, state_nxt;
    logic   load_en, accept, hazard, hold_load, issue, bubble, in_stall;

    logic [5:0]            held_funct, dec_funct;
    logic [REG_ADDR_W-1:0] held_rt, held_rd, dec_rt, dec_rd;
    logic [FLAGS_W-1:0]    held_flags, dec_flags;

    logic                  d_alu_en, d_src_b, d_agu_en, d_make_jump, d_wb_en, d_imm_sext, d_illegal;
    logic [1:0]            d_src_a;
    logic [ALU_OP_W-1:0]   d_alu_op;
    logic [AGU_OP_W-1:0]   d_agu_op;
    logic [REG_ADDR_W-1:0] d_wb_reg;

    assign load_en  = ~o_valid | i_out_ready;
    assign o_ready  = (state == ST_RUN) & load_en;
    assign accept   = i_valid & o_ready;
    assign hazard   = i_ex_load & (i_ex_rt != '0) & ((i_ex_rt == i_rs) | (i_ex_rt == i_rt));
    assign in_stall = (state == ST_STALL);

    // The held instruction is decoded while the bubble drains.
    assign dec_funct = in_stall ? held_funct : i_funct;
    assign dec_rt    = in_stall ? held_rt    : i_rt;
    assign dec_rd    = in_stall ? held_rd    : i_rd;
    assign dec_flags = in_stall ? held_flags : i_flags;

    ctrl_decode #(
        .REG_ADDR_W (REG_ADDR_W),
        .ALU_OP_W   (ALU_OP_W),
        .AGU_OP_W   (AGU_OP_W)
    ) u_decode (
        .funct     (dec_funct),
        .rt        (dec_rt),
        .rd        (dec_rd),
        .flags     (dec_flags),
        .alu_en    (d_alu_en),
        .src_a     (d_src_a),
        .src_b     (d_src_b),
        .alu_op    (d_alu_op),
        .agu_en    (d_agu_en),
        .agu_op    (d_agu_op),
        .make_jump (d_make_jump),
        .wb_en     (d_wb_en),
        .wb_reg    (d_wb_reg),
        .imm_sext  (d_imm_sext),
        .illegal   (d_illegal)
    );

    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        issue     = 1'b0;
        bubble    = 1'b0;
        if (i_flush) begin
            state_nxt = ST_RUN;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (accept && hazard) begin
                        hold_load = 1'b1;
                        bubble    = 1'b1;
                        state_nxt = ST_STALL;
                    end else if (accept) begin
                        issue = 1'b1;
                        if (HALT_ON_ILLEGAL && d_illegal) state_nxt = ST_HALT;
                    end
                end
                ST_STALL: begin
                    if (load_en) begin
                        issue     = 1'b1;
                        state_nxt = (HALT_ON_ILLEGAL && d_illegal) ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: if (i_resume) state_nxt = ST_RUN;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (hold_load) begin
            held_funct <= i_funct;
            held_rt    <= i_rt;
            held_rd    <= i_rd;
            held_flags <= i_flags;
        end
    end

    // Output register; a flush forces issue/bubble low and so loads an empty word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_stall     <= 1'b0;
            o_illegal   <= 1'b0;
            o_alu_en    <= 1'b0;
            o_alu_src_a <= '0;
            o_alu_src_b <= 1'b0;
            o_alu_op    <= '0;
            o_agu_en    <= 1'b0;
            o_agu_op    <= '0;
            o_make_jump <= 1'b0;
            o_wb_en     <= 1'b0;
            o_wb_reg    <= '0;
            o_imm_sext  <= 1'b0;
        end else if (i_flush || load_en) begin
            o_valid     <= issue | bubble;
            o_stall     <= bubble;
            o_illegal   <= issue & d_illegal;
            o_alu_en    <= issue & d_alu_en;
            o_alu_src_a <= issue ? d_src_a : '0;
            o_alu_src_b <= issue & d_src_b;
            o_alu_op    <= issue ? d_alu_op : '0;
            o_agu_en    <= issue & d_agu_en;
            o_agu_op    <= issue ? d_agu_op : '0;
            o_make_jump <= issue & d_make_jump;
            o_wb_en     <= issue & d_wb_en;
            o_wb_reg    <= issue ? d_wb_reg : '0;
            o_imm_sext  <= issue & d_imm_sext;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: expected control words are queued at
// acceptance and compared as the stage hands them downstream.
module tb_decode_ctrl_stage;
    import cpu_ctrl_pkg::*;

    localparam logic [11:0] F_R    = 12'h000;
    localparam logic [11:0] F_IMM  = 12'h020;
    localparam logic [11:0] F_LD   = 12'h010;
    localparam logic [11:0] F_ST   = 12'h018;
    localparam logic [11:0] F_BR   = 12'h880;
    localparam logic [11:0] F_JR   = 12'h800;
    localparam logic [11:0] F_JALR = 12'hC00;
    localparam logic [11:0] F_J    = 12'h900;
    localparam logic [11:0] F_JAL  = 12'hD00;
    localparam logic [21:0] W_BUBBLE  = 22'h200000;
    localparam logic [21:0] W_ILLEGAL = 22'h100000;

    logic clk = 1'b0;
    logic rst_n, i_valid, i_ex_load, i_flush, i_resume, i_out_ready;
    logic [5:0] i_funct;
    logic [4:0] i_rs, i_rt, i_rd, i_ex_rt;
    logic [11:0] i_flags;
    logic o_ready, o_valid, o_alu_en, o_alu_src_b, o_agu_en, o_make_jump;
    logic o_wb_en, o_imm_sext, o_illegal, o_stall;
    logic [1:0] o_alu_src_a;
    logic [3:0] o_alu_op;
    logic [2:0] o_agu_op;
    logic [4:0] o_wb_reg;
    logic [21:0] obs_w;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    decode_ctrl_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct(i_funct), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_flags(i_flags),
        .i_ex_load(i_ex_load), .i_ex_rt(i_ex_rt), .i_flush(i_flush), .i_resume(i_resume),
        .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_alu_en(o_alu_en), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_alu_op(o_alu_op), .o_agu_en(o_agu_en), .o_agu_op(o_agu_op),
        .o_make_jump(o_make_jump), .o_wb_en(o_wb_en), .o_wb_reg(o_wb_reg),
        .o_imm_sext(o_imm_sext), .o_illegal(o_illegal), .o_stall(o_stall)
    );

    assign obs_w = {o_stall, o_illegal, o_alu_en, o_alu_src_a, o_alu_src_b, o_alu_op,
                    o_agu_en, o_agu_op, o_make_jump, o_wb_en, o_wb_reg, o_imm_sext};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] model(input logic [5:0] f, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [11:0] fl);
        logic ae, sb, ge, mj, we, sx, il;
        logic [1:0] sa;
        logic [3:0] op;
        logic [2:0] go;
        logic [4:0] wr;
        ae = 0; sb = 0; ge = 0; mj = 0; we = 0; sx = 0; il = 0;
        sa = 2'b00; op = 4'b0000; go = 3'b000; wr = 5'd0;
        if (fl[4]) begin
            ge = 1; go = 3'b001; we = !fl[3]; wr = rt;
        end else if (fl[11] && fl[7]) begin
            ae = 1; op = 4'b0101; sa = 2'b01; ge = 1; go = 3'b010; mj = 1;
        end else if (fl[11] && fl[9:8] == 2'b00) begin
            ge = 1; go = 3'b000; mj = 1;
            if (fl[10]) begin ae = 1; op = 4'b0100; we = 1; wr = rd; end
        end else if (fl[11] && fl[9:8] == 2'b01) begin
            ge = 1; go = 3'b011; mj = 1;
            if (fl[10]) begin ae = 1; op = 4'b0100; we = 1; wr = 5'd31; end
        end else if (fl[5]) begin
            ae = 1; sa = 2'b11; we = 1; wr = rt;
            case (f[2:0])
                3'b000: begin op = ALU_SIGNED_ADD; sx = 1; end
                3'b010: begin op = ALU_SLT; sx = 1; end
                3'b100: op = ALU_AND;
                3'b101: op = ALU_OR;
                3'b110: op = ALU_XOR;
                3'b111: op = ALU_SHIFT_LEFT;
                default: il = 1;
            endcase
        end else begin
            ae = 1; sa = 2'b01; we = 1; wr = rd;
            case (f)
                6'b000000: begin op = ALU_SLL; sb = 1; end
                6'b000010: begin op = ALU_SRL; sb = 1; end
                6'b000011: begin op = ALU_SRA; sb = 1; end
                6'b000100: op = ALU_SLL;
                6'b000110: op = ALU_SRL;
                6'b000111: op = ALU_SRA;
                6'b100001: op = 4'b0100;
                6'b100011: op = 4'b0101;
                6'b100100: op = ALU_AND;
                6'b100101: op = ALU_OR;
                6'b100110: op = ALU_XOR;
                6'b100111: op = ALU_NOR;
                6'b101010: op = ALU_SLT;
                default: il = 1;
            endcase
        end
        if (wr == 5'd0) we = 0;
        if (il) return W_ILLEGAL;
        return {1'b0, 1'b0, ae, sa, sb, op, ge, go, mj, we, wr, sx};
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_valid && i_out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk($sformatf("out%0d_unexpected", n_out), 32'(exp_q.size()), 1);
            else chk($sformatf("out%0d_word", n_out), 32'(obs_w), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [11:0] fl,
                        input logic exl, input logic [4:0] exrt);
        logic acc;
        int n;
        i_valid = 1; i_funct = f; i_rs = rs; i_rt = rt; i_rd = rd; i_flags = fl;
        i_ex_load = exl; i_ex_rt = exrt;
        acc = 0; n = 0;
        while (!acc && n < 40) begin
            @(negedge clk); acc = o_ready;
            @(posedge clk); #1; n++;
        end
        if (!acc) chk("accept_timeout", 32'(n), 0);
        else begin
            if (exl && exrt != 0 && (exrt == rs || exrt == rt)) exp_q.push_back(W_BUBBLE);
            exp_q.push_back(model(f, rt, rd, fl));
        end
        i_valid = 0; i_ex_load = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; i_valid = 0; i_ex_load = 0; i_flush = 0; i_resume = 0; i_out_ready = 1;
        i_funct = 0; i_rs = 0; i_rt = 0; i_rd = 0; i_flags = 0; i_ex_rt = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_word", 32'(obs_w), 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 1);
        tick();

        // Plain decode across classes
        send(6'b100001, 5'd1, 5'd2, 5'd3, F_R, 0, 0);
        send(6'b000000, 5'd0, 5'd2, 5'd4, F_R, 0, 0);
        send(6'b000111, 5'd1, 5'd2, 5'd5, F_R, 0, 0);
        send(6'b100111, 5'd1, 5'd2, 5'd6, F_R, 0, 0);
        send(6'b101010, 5'd1, 5'd2, 5'd7, F_R, 0, 0);
        send(6'b100011, 5'd1, 5'd2, 5'd0, F_R, 0, 0);
        send(6'b000000, 5'd1, 5'd7, 5'd0, F_IMM, 0, 0);
        send(6'b000111, 5'd1, 5'd8, 5'd0, F_IMM, 0, 0);
        send(6'b000110, 5'd1, 5'd9, 5'd0, F_IMM, 0, 0);
        send(6'b000000, 5'd1, 5'd8, 5'd0, F_LD, 0, 0);
        send(6'b000000, 5'd1, 5'd8, 5'd0, F_ST, 0, 0);
        send(6'b000000, 5'd1, 5'd2, 5'd0, F_BR, 0, 0);
        send(6'b000000, 5'd1, 5'd0, 5'd0, F_JR, 0, 0);
        send(6'b000000, 5'd1, 5'd0, 5'd31, F_JALR, 0, 0);
        send(6'b000000, 5'd0, 5'd0, 5'd0, F_J, 0, 0);
        send(6'b000000, 5'd0, 5'd0, 5'd0, F_JAL, 0, 0);

        // Load-use hazards and near misses
        send(6'b100001, 5'd5, 5'd2, 5'd6, F_R, 1, 5'd5);
        send(6'b100100, 5'd1, 5'd9, 5'd10, F_R, 1, 5'd9);
        send(6'b100101, 5'd0, 5'd0, 5'd11, F_R, 1, 5'd0);
        send(6'b100110, 5'd3, 5'd4, 5'd12, F_R, 1, 5'd7);
        send(6'b100001, 5'd1, 5'd2, 5'd13, F_R, 0, 0);

        // Downstream back-pressure for three cycles
        send(6'b100001, 5'd1, 5'd2, 5'd14, F_R, 0, 0);
        i_out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(o_valid), 1);
            chk("hold_ready", 32'(o_ready), 0);
            chk("hold_word", 32'(obs_w), 32'(model(6'b100001, 5'd2, 5'd14, F_R)));
            tick();
        end
        i_out_ready = 1;
        @(negedge clk);
        chk("release_ready", 32'(o_ready), 1);
        tick();

        // Illegal R-type halts until resume
        send(6'b000001, 5'd1, 5'd2, 5'd3, F_R, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_ready", 32'(o_ready), 0);
            tick();
        end
        i_resume = 1;
        tick();
        i_resume = 0;
        @(negedge clk);
        chk("resume_ready", 32'(o_ready), 1);
        tick();

        // Illegal immediate halts; a flush with a live input leaves HALT and drops it
        send(6'b000011, 5'd1, 5'd2, 5'd3, F_IMM, 0, 0);
        @(negedge clk);
        chk("imm_halt_ready", 32'(o_ready), 0);
        tick();
        i_flush = 1; i_valid = 1; i_funct = 6'b100001; i_rd = 5'd9; i_flags = F_R;
        tick();
        i_flush = 0; i_valid = 0;
        @(negedge clk);
        chk("flush_halt_valid", 32'(o_valid), 0);
        chk("flush_halt_ready", 32'(o_ready), 1);
        tick();

        // Flush while the held instruction waits behind its bubble
        send(6'b100001, 5'd6, 5'd2, 5'd15, F_R, 1, 5'd6);
        i_flush = 1;
        void'(exp_q.pop_back());
        tick();
        i_flush = 0;
        @(negedge clk);
        chk("flush_stall_valid", 32'(o_valid), 0);
        chk("flush_stall_ready", 32'(o_ready), 1);
        tick();

        // Reset asserted during a stall
        send(6'b100001, 5'd7, 5'd2, 5'd16, F_R, 1, 5'd7);
        rst_n = 0;
        exp_q.delete();
        #1;
        chk("rst_stall_valid", 32'(o_valid), 0);
        chk("rst_stall_word", 32'(obs_w), 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rst_stall_ready", 32'(o_ready), 1);
        tick();
        send(6'b100101, 5'd1, 5'd2, 5'd17, F_R, 0, 0);

        repeat (5) tick();
        chk("drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
